// File: rtl/apb_exe_if.sv
// APB slave front-end for the execution unit: operand/op registers, run sequencer,
// and result/status capture.
module apb_exe_if #(
  parameter int unsigned M   = 8,
  parameter int unsigned LAT = 1,
  parameter int unsigned AW  = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_psel,
  input  logic          i_penable,
  input  logic          i_pwrite,
  input  logic [AW-1:0] i_paddr,
  input  logic [M-1:0]  i_pwdata,
  output logic [M-1:0]  o_prdata,
  output logic          o_pready,
  output logic          o_pslverr,
  output logic [M-1:0]  o_argA,
  output logic [M-1:0]  o_argB,
  output logic [1:0]    o_op,
  output logic          o_start,
  input  logic [M-1:0]  i_y,
  input  logic          i_error
);

  localparam int unsigned CW = $clog2(LAT + 1);

  localparam logic [AW-1:0] ADDR_ARG_A  = AW'(0);
  localparam logic [AW-1:0] ADDR_ARG_B  = AW'(1);
  localparam logic [AW-1:0] ADDR_CTRL   = AW'(2);
  localparam logic [AW-1:0] ADDR_RESULT = AW'(3);
  localparam logic [AW-1:0] ADDR_STATUS = AW'(4);

  typedef enum logic {IDLE, RUN} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   arga_q, arga_d;
  logic [M-1:0]   argb_q, argb_d;
  logic [1:0]     op_q, op_d;
  logic           start_q, start_d;
  logic [M-1:0]   result_q, result_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic           access_c;
  logic           run_c;
  logic           pready_c;
  logic           xfer_c;
  logic           bad_c;
  logic           wr_ok_c;
  logic [M-1:0]   rdata_c;

  // APB decode; o_pready/o_prdata/o_pslverr are combinational views of the bus phase
  always_comb begin
    access_c = i_psel & i_penable;
    run_c    = (state_q == RUN);
    pready_c = ~(access_c & ~i_pwrite & (i_paddr == ADDR_RESULT) & run_c);
    xfer_c   = access_c & pready_c;
    bad_c    = 1'b0;
    rdata_c  = '0;
    if (i_pwrite) begin
      bad_c = run_c || !((i_paddr == ADDR_ARG_A) || (i_paddr == ADDR_ARG_B) ||
                         (i_paddr == ADDR_CTRL));
    end else begin
      case (i_paddr)
        ADDR_ARG_A:  rdata_c = arga_q;
        ADDR_ARG_B:  rdata_c = argb_q;
        ADDR_CTRL:   rdata_c = M'({op_q, 1'b0});
        ADDR_RESULT: rdata_c = result_q;
        ADDR_STATUS: rdata_c = M'({run_c, err_q, done_q});
        default:     bad_c = 1'b1;
      endcase
    end
    wr_ok_c   = xfer_c & i_pwrite & ~bad_c;
    o_pready  = pready_c;
    o_pslverr = xfer_c & bad_c;
    o_prdata  = (xfer_c & ~i_pwrite & ~bad_c) ? rdata_c : '0;
  end

  // Register writes and run sequencing
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    arga_d   = arga_q;
    argb_d   = argb_q;
    op_d     = op_q;
    start_d  = 1'b0;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (wr_ok_c) begin
          case (i_paddr)
            ADDR_ARG_A: arga_d = i_pwdata;
            ADDR_ARG_B: argb_d = i_pwdata;
            ADDR_CTRL: begin
              op_d = i_pwdata[2:1];
              if (i_pwdata[0]) begin
                state_d = RUN;
                cnt_d   = CW'(LAT);
                start_d = 1'b1;
                done_d  = 1'b0;
                err_d   = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = IDLE;
          result_d = i_y;
          err_d    = i_error;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      arga_q   <= '0;
      argb_q   <= '0;
      op_q     <= '0;
      start_q  <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      arga_q   <= arga_d;
      argb_q   <= argb_d;
      op_q     <= op_d;
      start_q  <= start_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign o_argA  = arga_q;
  assign o_argB  = argb_q;
  assign o_op    = op_q;
  assign o_start = start_q;

endmodule
